// File: rtl/divide_joiner_pkg.sv
// Shared constants and helpers for the divider operand joiner.
// No logic; widths and constants only.
package divide_joiner_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int CNT_W          = 8;
  localparam int ONE_DIVISOR    = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/divide_operand_fifo.sv
// Synchronous operand FIFO; head visible combinationally, 1-cycle push-to-head latency.
// Backpressure: full blocks push even when popping the same cycle; pop on empty is ignored.
module divide_operand_fifo
  import divide_joiner_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_dat
);

  localparam int AW = clog2(FIFO_DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              do_push;
  logic              do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/divide_operand_joiner_64.sv
// Pairs dividend/divisor streams and issues them together to the divider; 1-cycle issue latency.
// Backpressure: tready = !full per operand FIFO; divider side has none, credit counter caps in-flight pairs.
module divide_operand_joiner_64
  import divide_joiner_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  output logic              m_axis_a_tvalid,
  output logic [DATA_W-1:0] m_axis_a_tdata,
  output logic              m_axis_b_tvalid,
  output logic [DATA_W-1:0] m_axis_b_tdata,
  output logic              m_div_by_zero,
  input  logic              result_tvalid,
  output logic [7:0]        inflight,
  output logic              credit_err
);

  logic              ready_en;
  logic              a_full;
  logic              a_empty;
  logic              b_full;
  logic              b_empty;
  logic [DATA_W-1:0] a_head;
  logic [DATA_W-1:0] b_head;
  logic              a_push;
  logic              b_push;
  logic              credit_ok;
  logic              issue;
  logic              b_zero;

  // Ready stays low while in reset and rises on the first edge after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  assign s_axis_a_tready = ready_en && !a_full;
  assign s_axis_b_tready = ready_en && !b_full;
  assign a_push          = s_axis_a_tvalid && s_axis_a_tready;
  assign b_push          = s_axis_b_tvalid && s_axis_b_tready;

  // A same-cycle returning result frees the slot this issue consumes.
  assign credit_ok = (inflight < CNT_W'(MAX_INFLIGHT)) || result_tvalid;
  assign issue     = !a_empty && !b_empty && credit_ok;
  assign b_zero    = (b_head == '0);

  divide_operand_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_a_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (a_push),
    .push_dat (s_axis_a_tdata),
    .pop      (issue),
    .full     (a_full),
    .empty    (a_empty),
    .head_dat (a_head)
  );

  divide_operand_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_b_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (b_push),
    .push_dat (s_axis_b_tdata),
    .pop      (issue),
    .full     (b_full),
    .empty    (b_empty),
    .head_dat (b_head)
  );

  // Data registers hold the last issued pair between strobes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_a_tvalid <= 1'b0;
      m_axis_b_tvalid <= 1'b0;
      m_axis_a_tdata  <= '0;
      m_axis_b_tdata  <= '0;
      m_div_by_zero   <= 1'b0;
    end else begin
      m_axis_a_tvalid <= issue;
      m_axis_b_tvalid <= issue;
      m_div_by_zero   <= issue && b_zero;
      if (issue) begin
        m_axis_a_tdata <= a_head;
        m_axis_b_tdata <= b_zero ? DATA_W'(ONE_DIVISOR) : b_head;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight   <= '0;
      credit_err <= 1'b0;
    end else begin
      case ({issue, result_tvalid})
        2'b10: inflight <= inflight + CNT_W'(1);
        2'b01: begin
          if (inflight == '0) credit_err <= 1'b1;
          else                inflight   <= inflight - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divide_operand_joiner_64.md
Name: divide_operand_joiner_64

Overview:
Upstream feeder for the 64/64 fixed-point divider wrapper, whose a/b inputs carry tvalid only (no backpressure). Accepts dividend (a) and divisor (b) on two independent ready/valid streams, buffers each in a small FIFO, and issues them as a matched pair in the same cycle. A credit counter caps divisions in flight; a zero divisor is replaced by 1 and flagged.

Parameters:
DATA_W, 64, operand width (a and b).
FIFO_DEPTH, 8, entries per operand FIFO; power of two, >= 2.
MAX_INFLIGHT, 16, maximum issued pairs whose results have not yet returned; 1..255.

Ports:
aclk  in  1  clock, rising edge.
aresetn  in  1  asynchronous active-low reset.
s_axis_a_tvalid  in  1  dividend valid.
s_axis_a_tready  out  1  dividend FIFO not full.
s_axis_a_tdata  in  DATA_W  dividend.
s_axis_b_tvalid  in  1  divisor valid.
s_axis_b_tready  out  1  divisor FIFO not full.
s_axis_b_tdata  in  DATA_W  divisor.
m_axis_a_tvalid  out  1  dividend issue strobe, to divider a_tvalid.
m_axis_a_tdata  out  DATA_W  dividend to divider.
m_axis_b_tvalid  out  1  divisor issue strobe, to divider b_tvalid.
m_axis_b_tdata  out  DATA_W  divisor to divider (zero replaced by 1).
m_div_by_zero  out  1  high with the issue strobe when original divisor was 0.
result_tvalid  in  1  divider m_axis_result_tvalid; returns one credit.
inflight  out  8  current outstanding count.
credit_err  out  1  sticky: result_tvalid seen with inflight == 0.

Behaviour:
- Reset (aresetn low, async): both FIFOs empty, all m_* outputs 0, inflight 0, credit_err 0, both tready 0 while reset asserted; tready = !full from first edge after release.
- Accept: a pushed on edge when s_axis_a_tvalid & s_axis_a_tready; b likewise; channels fully independent.
- tready = !full only; a full FIFO accepts no push even if popping in the same cycle.
- Issue condition (evaluated each cycle): a_fifo non-empty & b_fifo non-empty & (inflight < MAX_INFLIGHT | result_tvalid).
- On issue: both FIFOs pop on the same edge; registered outputs m_axis_a_tvalid = m_axis_b_tvalid = 1 for exactly one cycle, data = FIFO heads; no backpressure from divider.
- Latency: pair whose later operand is accepted at edge E appears on m outputs after edge E+1 (valid during cycle after E+1). Back-to-back issue every cycle sustained when both FIFOs hold data and credit available.
- m_axis_*_tvalid never asserted without its partner; m_axis_a_tvalid == m_axis_b_tvalid always.
- Outputs when not issuing: tvalid 0, m_div_by_zero 0, tdata holds last issued value.
- Zero divisor: head b == 0 -> m_axis_b_tdata = 1, m_div_by_zero = 1 on that issue; dividend unchanged.
- Credit: inflight_next = inflight + issue - result_tvalid; simultaneous issue and return leaves count unchanged and permits issue at inflight == MAX_INFLIGHT.
- result_tvalid with inflight == 0 and no same-cycle issue: count stays 0, credit_err set, sticky until reset.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty via extra pointer bit.
- Reset mid-operation discards buffered operands and in-flight accounting; results arriving after reset release count as credit_err.

Decomposition:
- Package divide_joiner_pkg: DATA_W default, CNT_W = 8, localparam ONE_DIVISOR = 1, function clog2.
- Sub-module divide_operand_fifo: synchronous FIFO (DATA_W, FIFO_DEPTH), push/pop/full/empty/head, same aclk/aresetn; instantiated twice.

Test Plan:
- Reset, then a=0x50 at cycle 0, b=0x5 at cycle 3 -> single issue strobe one cycle after b accept edge, a=0x50, b=0x5, m_div_by_zero 0, inflight 1.
- Push 8 a with no b -> s_axis_a_tready low after 8th, no issue; then push 8 b back-to-back -> 8 consecutive-cycle pairs in original order.
- b=0, a=0x1234 -> m_axis_b_tdata=1, m_div_by_zero=1 for one cycle.
- MAX_INFLIGHT=16, 20 pairs buffered, no result_tvalid -> exactly 16 issues, inflight 16, stall; one result_tvalid pulse -> one more issue same cycle, inflight stays 16.
- result_tvalid pulse at inflight 0 -> inflight 0, credit_err 1 and remains 1 until aresetn.
- aresetn pulsed low mid-stream with 3 pairs buffered -> outputs 0 immediately (async), FIFOs empty, no issue after release until new pushes.
